// File: rtl/gpio_serializer_p.sv
// Parallel-to-serial GPIO transmitter: one-word holding register feeding a shifter with programmable bit period.
// Optional even-parity bit after the data bits when SER_PARITY_EN is defined.
module gpio_serializer_p #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              done,
  output logic              busy
);

`ifdef SER_PARITY_EN
  localparam int unsigned FL = DATA_W + 1;
`else
  localparam int unsigned FL = DATA_W;
`endif
  localparam int unsigned BW = (FL > 1) ? $clog2(FL) : 1;
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [FL-1:0]     shreg;
  logic [FL-1:0]     frame;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              accept;
  logic              last;
  logic              load;

  assign s_ready = !hold_full;
  assign accept  = s_valid && !hold_full;
  assign last    = (state == SHIFT) && (bit_cnt == BIT_LAST) && (div_cnt == '0);
  assign load    = hold_full && ((state == IDLE) || last);

  // Frame is laid out so that bit 0 is always the first one on the wire.
  always_comb begin
    frame = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      frame[i] = MSB_FIRST ? hold[int'(DATA_W) - 1 - i] : hold[i];
    end
`ifdef SER_PARITY_EN
    frame[FL-1] = ^hold;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      ser_out   <= IDLE_LVL;
      ser_en    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= last;
      busy <= load || ((state == SHIFT) && !last) || accept || (hold_full && !load);

      if (accept) begin
        hold      <= s_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      // A pending word is loaded on the last bit's final edge, keeping back-to-back frames gap-free.
      if (load) begin
        state   <= SHIFT;
        shreg   <= frame;
        ser_out <= frame[0];
        ser_en  <= 1'b1;
        bit_cnt <= '0;
        div_cnt <= DIV_LAST;
      end else if (last) begin
        state   <= IDLE;
        ser_out <= IDLE_LVL;
        ser_en  <= 1'b0;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (state == SHIFT) begin
        if (div_cnt == '0) begin
          shreg   <= shreg >> 1;
          ser_out <= shreg[1];
          bit_cnt <= bit_cnt + 1'b1;
          div_cnt <= DIV_LAST;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_serializer_p.sv
// Directed bench for gpio_serializer_p: default 8-bit MSB-first instance plus a DIV=3, LSB-first, idle-high instance.
// Expected frame length follows SER_PARITY_EN the same way the design does.
module tb_gpio_serializer_p;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_valid3;
  logic [7:0] s_data, s_data3;
  logic       s_ready, ser_out, ser_en, done, busy;
  logic       s_ready3, ser_out3, ser_en3, done3, busy3;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  gpio_serializer_p #(.DATA_W(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ser_out(ser_out), .ser_en(ser_en), .done(done), .busy(busy)
  );

  gpio_serializer_p #(.DATA_W(8), .DIV(3), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
    .ser_out(ser_out3), .ser_en(ser_en3), .done(done3), .busy(busy3)
  );

  // Reference bit i of a frame: data bits in chosen order, then the even-parity bit.
  function automatic logic expBit(input logic [7:0] w, input int i, input bit msb);
    if (i < 8) return msb ? w[7-i] : w[i];
    return ^w;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single frame on the DIV=1 instance, accepted on the next edge with the shifter idle.
  task automatic sendFrame(input logic [7:0] w);
    s_valid = 1'b1;
    s_data  = w;
    applyStimulus();
    s_valid = 1'b0;
    checkOutput("accept_ready_low", s_ready, 0);
    checkOutput("accept_busy", busy, 1);
    checkOutput("pre_first_bit_en", ser_en, 0);
    applyStimulus();
    for (int i = 0; i < FL; i++) begin
      checkOutput($sformatf("frame_%02h_bit%0d", w, i), ser_out, expBit(w, i, 1'b1));
      checkOutput($sformatf("frame_%02h_en%0d", w, i), ser_en, 1);
      checkOutput($sformatf("frame_%02h_nodone%0d", w, i), done, 0);
      applyStimulus();
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("post_en", ser_en, 0);
    checkOutput("post_idle_lvl", ser_out, 0);
    checkOutput("post_busy", busy, 0);
    applyStimulus();
    checkOutput("done_one_cycle", done, 0);
  endtask

  // Offers n words continuously and checks order, contiguity, accept and done timing.
  task automatic streamWords(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int n);
    logic [7:0] words [3];
    logic       bits [$];
    int         idx = 0;
    int         dones = 0;
    int         runs = 0;
    int         acceptCyc [3];
    int         doneCyc [3];
    logic       prevEn = 1'b0;
    logic       willAccept;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    s_valid  = 1'b1;
    s_data   = words[0];
    for (int cyc = 0; cyc < 3 * FL + 12; cyc++) begin
      willAccept = s_valid && s_ready;
      if (willAccept) acceptCyc[idx] = cyc;
      if (ser_en) bits.push_back(ser_out);
      if (ser_en && !prevEn) runs++;
      prevEn = ser_en;
      if (done) begin
        if (dones < 3) doneCyc[dones] = cyc;
        dones++;
      end
      applyStimulus();
      if (willAccept) begin
        idx++;
        if (idx < n) s_data = words[idx];
        else begin
          s_valid = 1'b0;
          s_data  = 8'h00;
        end
      end
    end
    checkOutput("stream_accepts", idx, n);
    checkOutput("stream_bitcount", bits.size(), n * FL);
    checkOutput("stream_one_run", runs, 1);
    checkOutput("stream_dones", dones, n);
    if (n >= 2) checkOutput("stream_second_accept_cycle", acceptCyc[1], 2);
    for (int j = 0; j < n && j < dones; j++)
      checkOutput($sformatf("stream_done_cycle%0d", j), doneCyc[j], 2 + (j + 1) * FL);
    for (int b = 0; b < n * FL && b < bits.size(); b++)
      checkOutput($sformatf("stream_bit%0d", b), bits[b], expBit(words[b / FL], b % FL, 1'b1));
  endtask

  initial begin
    int stray;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_valid3 = 1'b0;
    s_data3  = 8'h00;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_ser_out", ser_out, 0);
    checkOutput("reset_ser_en", ser_en, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_s_ready", s_ready, 1);
    checkOutput("reset_idle_high", ser_out3, 1);
    rst_n = 1'b1;
    applyStimulus();

    sendFrame(8'hA5);
    sendFrame(8'h07);
    sendFrame(8'h03);

    streamWords(8'h3C, 8'hC3, 8'h00, 2);
    applyStimulus();
    streamWords(8'h11, 8'h22, 8'h33, 3);
    applyStimulus();

    // Slow LSB-first instance: each bit lasts three cycles and the line idles high.
    s_valid3 = 1'b1;
    s_data3  = 8'h01;
    applyStimulus();
    s_valid3 = 1'b0;
    applyStimulus();
    for (int c = 0; c < 3 * FL; c++) begin
      checkOutput($sformatf("div3_bit_cycle%0d", c), ser_out3, expBit(8'h01, c / 3, 1'b0));
      checkOutput($sformatf("div3_en_cycle%0d", c), ser_en3, 1);
      checkOutput($sformatf("div3_nodone%0d", c), done3, 0);
      applyStimulus();
    end
    checkOutput("div3_done", done3, 1);
    checkOutput("div3_idle_lvl", ser_out3, 1);
    checkOutput("div3_post_en", ser_en3, 0);
    applyStimulus();

    // Reset during bit 4 of 0xFF while a second word sits in the holding register.
    s_valid = 1'b1;
    s_data  = 8'hFF;
    applyStimulus();
    s_data  = 8'h5A;
    applyStimulus();
    checkOutput("rst_pending_ready", s_ready, 1);
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("rst_bit4_value", ser_out, 1);
    checkOutput("rst_bit4_en", ser_en, 1);
    checkOutput("rst_bit4_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ser_out", ser_out, 0);
    checkOutput("rst_async_ser_en", ser_en, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_done", done, 0);
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("rst_release_ready", s_ready, 1);
    checkOutput("rst_release_busy", busy, 0);
    stray = 0;
    for (int c = 0; c < 3 * FL; c++) begin
      if (ser_en || done || busy) stray++;
      applyStimulus();
    end
    checkOutput("rst_no_residual", stray, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
